// File: rtl/sram_like_ram_slave.sv
// sram_like_ram_slave: data-side sram-like responder backed by an internal
// word RAM (2^ADDR_W x 32). Answers one request at a time, LATENCY cycles
// after the address handshake.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   data_req/wr/size     request valid, write flag, size (0 B,1 H,2/3 W)
//   data_addr/wdata      byte address, lane-positioned write data
//   data_rdata           read word, valid with data_data_ok
//   data_addr_ok         request accepted this cycle
//   data_data_ok         one-cycle response pulse
//
// Optional feature macro: SRAM_LIKE_RANDOM_BP_EN
//   When defined, an LFSR randomly withholds data_addr_ok in IDLE.

module sram_like_ram_slave #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT =
        (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [1:0]         size_q, size_d;
    logic [ADDR_W+1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [31:0]        mem [DEPTH];

    logic               bp;
    logic               addr_ok;
    logic               hs;
    logic               enter_resp;

    // Fields used for the RAM access. With LATENCY=1 the access happens on
    // the same edge as the handshake, so the live inputs are used instead
    // of the (not yet loaded) latched copies.
    logic               acc_wr;
    logic [1:0]         acc_size;
    logic [ADDR_W+1:0]  acc_addr;
    logic [31:0]        acc_wdata;
    logic [ADDR_W-1:0]  acc_idx;
    logic [3:0]         acc_mask;
    logic               mem_we;

    // Upper address bits alias onto the RAM and are deliberately dropped.
    logic               unused_addr_hi;
    assign unused_addr_hi = ^data_addr[31:ADDR_W+2];

`ifdef SRAM_LIKE_RANDOM_BP_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    // Fibonacci LFSR, taps 16,14,13,11.
    always_comb begin
        lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d  = {lfsr_q[14:0], lfsr_fb};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bp = lfsr_q[0] & lfsr_q[1];
`else
    assign bp = 1'b0;
`endif

    // Decoded from registered state only: no path from data_req.
    assign addr_ok = (state_q == S_IDLE) & ~bp;
    assign hs      = data_req & addr_ok;

    always_comb begin
        if (state_q == S_IDLE) begin
            acc_wr    = data_wr;
            acc_size  = data_size;
            acc_addr  = data_addr[ADDR_W+1:0];
            acc_wdata = data_wdata;
        end else begin
            acc_wr    = wr_q;
            acc_size  = size_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    assign acc_idx = acc_addr[ADDR_W+1:2];

    always_comb begin
        acc_mask = 4'b0000;
        unique case (acc_size)
            2'd0: acc_mask = 4'b0001 << acc_addr[1:0];
            2'd1: acc_mask = acc_addr[1] ? 4'b1100 : 4'b0011;
            default: acc_mask = 4'b1111;
        endcase
    end

    always_comb begin
        enter_resp = 1'b0;
        if (state_q == S_WAIT && cnt_q == 4'd0) begin
            enter_resp = 1'b1;
        end else if (hs && LATENCY == 1) begin
            enter_resp = 1'b1;
        end
    end

    // An edge that coincides with reset must not commit a write.
    assign mem_we = enter_resp & acc_wr & ~rst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (hs) begin
                    wr_d    = data_wr;
                    size_d  = data_size;
                    addr_d  = data_addr[ADDR_W+1:0];
                    wdata_d = data_wdata;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Read returns the whole word; lane alignment is the initiator's job.
    always_comb begin
        rdata_d = rdata_q;
        if (enter_resp && !acc_wr) begin
            rdata_d = mem[acc_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_mask[i]) begin
                    mem[acc_idx][i*8 +: 8] <= acc_wdata[i*8 +: 8];
                end
            end
        end
    end

    assign data_rdata   = rdata_q;
    assign data_addr_ok = addr_ok;
    assign data_data_ok = (state_q == S_RESP);

endmodule
